// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Each request becomes a two-beat RAM command; reads wait for RAM data with a timeout.
module ram_arbiter #(
  parameter int RD_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  output logic       a_err,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       b_err,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RD, DONE} state_t;

  localparam logic [7:0] TMO = 8'(RD_TIMEOUT);

  state_t     state, state_n;
  logic       last, last_n;   // 0 = A granted last, 1 = B
  logic       sel, sel_n;     // port owning the in-flight transaction
  logic       we_q, we_n;
  logic [7:0] addr_q, addr_n, wdata_q, wdata_n, cnt, cnt_n;
  logic [9:0] din_n;
  logic       rxv_n, fin, tmo, grant_b;
  logic [7:0] rd_val;

  // Outputs are registered, so each branch computes what the next state presents.
  always_comb begin
    state_n = state;
    last_n  = last;
    sel_n   = sel;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    cnt_n   = cnt;
    din_n   = 10'h000;
    rxv_n   = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    rd_val  = 8'h00;
    grant_b = b_req & (~a_req | ~last);
    case (state)
      IDLE: begin
        if (a_req | b_req) begin
          sel_n   = grant_b;
          last_n  = grant_b;
          we_n    = grant_b ? b_we : a_we;
          addr_n  = grant_b ? b_addr : a_addr;
          wdata_n = grant_b ? b_wdata : a_wdata;
          state_n = ADDR;
          rxv_n   = 1'b1;
          din_n   = {(we_n ? 2'b00 : 2'b10), addr_n};
        end
      end
      ADDR: begin
        state_n = DATA;
        rxv_n   = 1'b1;
        din_n   = we_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
      end
      DATA: begin
        if (we_q) begin
          state_n = DONE;
          fin     = 1'b1;
        end else begin
          cnt_n   = 8'h00;
          state_n = WAIT_RD;
        end
      end
      WAIT_RD: begin
        cnt_n = cnt + 8'd1;
        // RAM data beats the timeout when both land in the same cycle
        if (ram_tx_valid) begin
          fin     = 1'b1;
          rd_val  = ram_dout;
          state_n = DONE;
        end else if (cnt_n == TMO) begin
          fin     = 1'b1;
          tmo     = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      sel          <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      cnt          <= 8'h00;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_err        <= 1'b0;
      b_err        <= 1'b0;
      a_rdata      <= 8'h00;
      b_rdata      <= 8'h00;
    end else begin
      state        <= state_n;
      last         <= last_n;
      sel          <= sel_n;
      we_q         <= we_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      cnt          <= cnt_n;
      ram_din      <= din_n;
      ram_rx_valid <= rxv_n;
      a_ack        <= fin & ~sel;
      b_ack        <= fin & sel;
      a_err        <= fin & tmo & ~sel;
      b_err        <= fin & tmo & sel;
      if (fin & ~we_q & ~sel) a_rdata <= rd_val;
      if (fin & ~we_q & sel)  b_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: expected beats/acks are queued at issue time
// and a monitor compares them as the DUT presents RAM beats and acks.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0] a_addr = 8'h00, a_wdata = 8'h00, b_addr = 8'h00, b_wdata = 8'h00;
  logic       a_ack, a_err, b_ack, b_err, ram_rx_valid;
  logic [7:0] a_rdata, b_rdata;
  logic [9:0] ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_tx_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    logic       err;
  } ack_t;

  ack_t       ack_q[$];
  logic [9:0] beat_q[$];

  // RAM model controls: latency 0 = silent
  int         ram_lat = 1;
  int         stray_req = 0, stray_done = 0;
  logic [7:0] mem [256];
  logic [7:0] ma = 8'h00;
  int         run = 0;

  ram_arbiter #(.RD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  // Monitor: RAM beats and acks checked against the scoreboard queues.
  initial begin
    ack_t       e;
    logic [9:0] eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else begin
        if (ram_rx_valid) begin
          run++;
          checks++;
          if (beat_q.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected ram_din=%h", ram_din);
          end else begin
            eb = beat_q.pop_front();
            if (ram_din !== eb) begin
              errors++;
              $display("FAIL beat: ram_din=%h expected %h", ram_din, eb);
            end
          end
          if (run > 2) begin
            errors++;
            $display("FAIL rx_run: ram_rx_valid high %0d cycles, max 2", run);
          end
        end else begin
          run = 0;
        end
        if (a_ack || b_ack) begin
          checks++;
          if (ack_q.size() == 0) begin
            errors++;
            $display("FAIL ack: unexpected a_ack=%b b_ack=%b", a_ack, b_ack);
          end else begin
            e = ack_q.pop_front();
            if ({b_ack, a_ack} !== (e.port ? 2'b10 : 2'b01)) begin
              errors++;
              $display("FAIL ack_port: a_ack=%b b_ack=%b expected port %s", a_ack, b_ack, e.port ? "B" : "A");
            end else if ((e.port ? b_rdata : a_rdata) !== e.rdata) begin
              errors++;
              $display("FAIL rdata: got %h expected %h", e.port ? b_rdata : a_rdata, e.rdata);
            end else if ({b_err, a_err} !== (e.err ? (e.port ? 2'b10 : 2'b01) : 2'b00)) begin
              errors++;
              $display("FAIL err: a_err=%b b_err=%b expected err=%b", a_err, b_err, e.err);
            end
          end
        end else if (a_err || b_err) begin
          checks++;
          errors++;
          $display("FAIL err_no_ack: a_err=%b b_err=%b", a_err, b_err);
        end
      end
    end
  end

  // RAM model: stores writes, answers read triggers after ram_lat cycles.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (stray_req != stray_done) begin
        stray_done++;
        ram_dout     = 8'h77;
        ram_tx_valid = 1'b1;
        @(posedge clk); #1;
        ram_tx_valid = 1'b0;
      end else if (!rst && ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00, 2'b10: ma = ram_din[7:0];
          2'b01:        mem[ma] = ram_din[7:0];
          default: begin
            if (ram_lat > 0) begin
              k = ram_lat;
              repeat (k) @(posedge clk);
              #1;
              ram_dout     = mem[ma];
              ram_tx_valid = 1'b1;
              @(posedge clk); #1;
              ram_tx_valid = 1'b0;
            end
          end
        endcase
      end
    end
  end

  task automatic wait_ack(input logic p, input int en);
    int n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (p ? b_ack : a_ack) break;
      if (n >= 60) begin
        errors++;
        $display("FAIL ack_timeout: port %s no ack after %0d cycles", p ? "B" : "A", n);
        break;
      end
    end
    if (en != 0) begin
      checks++;
      if (n != en) begin
        errors++;
        $display("FAIL latency: port %s ack at cycle %0d expected %0d", p ? "B" : "A", n, en);
      end
    end
  endtask

  task automatic expect_txn(input logic p, input logic we, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] er, input logic ee);
    ack_t e;
    beat_q.push_back({(we ? 2'b00 : 2'b10), addr});
    beat_q.push_back(we ? {2'b01, wdata} : 10'h300);
    e.port = p; e.rdata = er; e.err = ee;
    ack_q.push_back(e);
  endtask

  // Called aligned just after a rising edge with the DUT idle.
  task automatic txn(input logic p, input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [7:0] er, input logic ee, input int en);
    expect_txn(p, we, addr, wdata, er, ee);
    if (p) begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
    else   begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
    wait_ack(p, en);
    @(posedge clk); #1;
    if (p) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({a_ack, b_ack, a_err, b_err, ram_rx_valid, ram_din, a_rdata, b_rdata} !== '0) begin
      errors++;
      $display("FAIL %s: outputs ack=%b%b err=%b%b rxv=%b din=%h rdata=%h/%h, all zero required",
               name, a_ack, b_ack, a_err, b_err, ram_rx_valid, ram_din, a_rdata, b_rdata);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #11;
    check_zero("reset_state");
    @(posedge clk); #1 rst = 1'b0;

    // write then read back through the RAM model
    txn(1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 4);
    txn(1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 5);
    txn(1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 5);
    // silent RAM: timeout, then a normal request
    ram_lat = 0;
    txn(1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b1, 8);
    ram_lat = 1;
    txn(1'b0, 1'b1, 8'h44, 8'h5A, 8'hA5, 1'b0, 4);
    // data in the exact timeout cycle wins
    ram_lat = 4;
    txn(1'b1, 1'b0, 8'h44, 8'h00, 8'h5A, 1'b0, 8);
    // data one cycle too late: timeout, late strobe ignored
    ram_lat = 5;
    txn(1'b1, 1'b0, 8'h44, 8'h00, 8'h00, 1'b1, 8);
    ram_lat = 1;
    repeat (3) @(posedge clk);
    #1 stray_req++;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (a_rdata !== 8'hA5 || b_rdata !== 8'h00) begin
      errors++;
      $display("FAIL stray_tx: rdata=%h/%h expected a5/00", a_rdata, b_rdata);
    end

    // both request from reset and keep requesting: A, B, A, B
    rst = 1'b1;
    #1 check_zero("reset_again");
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_txn(1'b0, 1'b1, 8'h10, 8'h11, 8'h00, 1'b0);
      expect_txn(1'b1, 1'b1, 8'h20, 8'h22, 8'h00, 1'b0);
    end
    a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'h11;
    b_we = 1'b1; b_addr = 8'h20; b_wdata = 8'h22;
    a_req = 1'b1; b_req = 1'b1;
    begin
      int acks = 0;
      for (int c = 0; c < 100 && acks < 4; c++) begin
        @(negedge clk);
        if (a_ack || b_ack) acks++;
      end
      checks++;
      if (acks != 4) begin
        errors++;
        $display("FAIL rr_acks: got %0d acks expected 4", acks);
      end
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // reset during B's DATA beat, A pending; A must win first afterwards
    beat_q.push_back(10'h066);
    beat_q.push_back(10'h199);
    b_we = 1'b1; b_addr = 8'h66; b_wdata = 8'h99; b_req = 1'b1;
    @(posedge clk); #1;
    a_we = 1'b1; a_addr = 8'h70; a_wdata = 8'h07; a_req = 1'b1;
    @(negedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1 check_zero("reset_mid");
    expect_txn(1'b0, 1'b1, 8'h70, 8'h07, 8'h00, 1'b0);
    expect_txn(1'b1, 1'b1, 8'h66, 8'h99, 8'h00, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    fork
      begin wait_ack(1'b0, 0); @(posedge clk); #1 a_req = 1'b0; end
      begin wait_ack(1'b1, 0); @(posedge clk); #1 b_req = 1'b0; end
    join

    repeat (5) @(negedge clk);
    checks++;
    if (ack_q.size() != 0 || beat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d acks and %0d beats still expected", ack_q.size(), beat_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
